// File: rtl/router_wbq.sv
// Write-back router: source select, DEPTH-entry {data, addr} FIFO drained under READY, registered read addresses.
// Optional same-cycle bypass from empty when ROUTER_WBQ_BYPASS_EN is defined.
module router_wbq #(
   parameter int DW = 24,
   parameter int AW = 5,
   parameter int NSRC = 2,
   parameter int DEPTH = 4,
   localparam int SW = $clog2(NSRC),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NSRC*DW-1:0] src,
   input  logic [SW-1:0]     sel_data,
   input  logic [AW-1:0]     DIR,
   input  logic              WRITE,
   output logic              busy,
   input  logic [AW-1:0]     ctl_a,
   input  logic [AW-1:0]     ctl_b,
   output logic [AW-1:0]     dira,
   output logic [AW-1:0]     dirb,
   input  logic              READY,
   output logic              write,
   output logic [DW-1:0]     data,
   output logic [AW-1:0]     dirw,
   output logic [CW-1:0]     count,
   output logic              overflow
);

   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

   occ_t state, state_next;

   logic [DW-1:0] data_mem [DEPTH];
   logic [AW-1:0] addr_mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count_next;
   logic [DW-1:0] sel_val;
   logic          head_valid;
   logic          push, pop;

   // Selects beyond NSRC fall through to zero but still produce a stored entry.
   always_comb begin
      sel_val = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (sel_data == SW'(k)) begin
            sel_val = src[k*DW +: DW];
         end
      end
   end

   assign busy       = (state == FULL);
   assign head_valid = (state != EMPTY);

   always_comb begin
      write = head_valid;
      pop   = head_valid && READY;
      push  = WRITE && !busy;
      data  = '0;
      dirw  = '0;
      if (head_valid) begin
         data = data_mem[rd_ptr];
         dirw = addr_mem[rd_ptr];
      end
`ifdef ROUTER_WBQ_BYPASS_EN
      // From empty the request is presented straight away; it is queued only if not taken.
      if (!head_valid && WRITE) begin
         write = 1'b1;
         data  = sel_val;
         dirw  = DIR;
         push  = !READY;
      end
`endif
   end

   always_comb begin
      count_next = count;
      state_next = PARTIAL;
      if (push && !pop) begin
         count_next = count + CW'(1);
      end else if (pop && !push) begin
         count_next = count - CW'(1);
      end
      if (count_next == '0) begin
         state_next = EMPTY;
      end else if (count_next == CW'(DEPTH)) begin
         state_next = FULL;
      end
   end

   // Occupancy state, pointers, sticky overflow and the read-address pipeline.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= EMPTY;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         overflow <= 1'b0;
         dira     <= '0;
         dirb     <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (WRITE && busy) begin
            overflow <= 1'b1;
         end
         dira <= ctl_a;
         dirb <= ctl_b;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET && push) begin
         data_mem[wr_ptr] <= sel_val;
         addr_mem[wr_ptr] <= DIR;
      end
   end

endmodule
